// File: rtl/Parameterize_JPEGLS.sv
// ---------------------------------------------------------------------------
// Parameterize_JPEGLS
// Shared JPEG-LS definitions used by the run-length blocks:
//   - default sample and mode-code widths
//   - mode codes driven on the run-length counter's mode output
//   - run state enumeration
//   - the J[RUNindex] table, as a lookup function
// No ports; imported with "import Parameterize_JPEGLS::*;".
// ---------------------------------------------------------------------------
package Parameterize_JPEGLS;

    localparam int PIXEL_LENGTH    = 8;
    localparam int MODE_LENGTH     = 2;
    localparam int RUN_INDEX_WIDTH = 5;
    localparam int RUN_CNT_WIDTH   = 16;

    localparam logic [RUN_INDEX_WIDTH-1:0] RUN_INDEX_MAX = 5'd31;

    localparam logic [1:0] MODE_REGULAR       = 2'd0;
    localparam logic [1:0] MODE_RUN_CONTINUE  = 2'd1;
    localparam logic [1:0] MODE_RUN_INTERRUPT = 2'd2;
    localparam logic [1:0] MODE_RUN_EOL       = 2'd3;

    typedef enum logic {
        ST_REGULAR = 1'b0,
        ST_RUN     = 1'b1
    } rlcState_t;

    // J[RUNindex]: the run segment at index i is 2^J[i] pixels long.
    function automatic logic [4:0] jTableLookup(input logic [4:0] runIndex);
        logic [4:0] j;
        case (runIndex)
            5'd0,  5'd1,  5'd2,  5'd3:  j = 5'd0;
            5'd4,  5'd5,  5'd6,  5'd7:  j = 5'd1;
            5'd8,  5'd9,  5'd10, 5'd11: j = 5'd2;
            5'd12, 5'd13, 5'd14, 5'd15: j = 5'd3;
            5'd16, 5'd17:               j = 5'd4;
            5'd18, 5'd19:               j = 5'd5;
            5'd20, 5'd21:               j = 5'd6;
            5'd22, 5'd23:               j = 5'd7;
            5'd24:                      j = 5'd8;
            5'd25:                      j = 5'd9;
            5'd26:                      j = 5'd10;
            5'd27:                      j = 5'd11;
            5'd28:                      j = 5'd12;
            5'd29:                      j = 5'd13;
            5'd30:                      j = 5'd14;
            default:                    j = 5'd15;
        endcase
        return j;
    endfunction

endpackage

// File: rtl/run_j_table.sv
// ---------------------------------------------------------------------------
// run_j_table
// Combinational J[RUNindex] lookup.
// Ports:
//   run_index_i  [4:0]  current run index (0..31)
//   j_o          [4:0]  J value for that index (0..15)
// ---------------------------------------------------------------------------
module run_j_table
    import Parameterize_JPEGLS::*;
(
    input  logic [4:0] run_index_i,
    output logic [4:0] j_o
);

    // Pure table lookup, shared definition lives in the package.
    always_comb begin
        j_o = jTableLookup(run_index_i);
    end

endmodule

// File: rtl/run_length_counter.sv
// ---------------------------------------------------------------------------
// run_length_counter
// JPEG-LS run-mode decision and run-length counting. One pixel per cycle,
// every output registered one cycle after its pixel, no backpressure.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid            pixel/context valid this cycle
//   frame_start         first pixel of an image (restarts run state)
//   eol                 pixel is last of its line
//   x, a, b, c, d       current sample and causal neighbours
//   out_valid           registered in_valid
//   mode                0 regular, 1 run continue, 2 interruption, 3 EOL end
//   x_out, a_out, b_out registered copies of x, a, b
//   run_hit             emit one '1' run bit
//   run_eol_bit         emit the '1' termination bit at end of line
//   run_cnt_out         residual run count at interruption
//   j_out               J[RUNindex] at interruption
// ---------------------------------------------------------------------------
module run_length_counter
    import Parameterize_JPEGLS::*;
#(
    parameter int pixel_length = PIXEL_LENGTH,
    parameter int mode_length  = MODE_LENGTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    frame_start,
    input  logic                    eol,
    input  logic [pixel_length-1:0] x,
    input  logic [pixel_length-1:0] a,
    input  logic [pixel_length-1:0] b,
    input  logic [pixel_length-1:0] c,
    input  logic [pixel_length-1:0] d,
    output logic                    out_valid,
    output logic [mode_length-1:0]  mode,
    output logic [pixel_length-1:0] x_out,
    output logic [pixel_length-1:0] a_out,
    output logic [pixel_length-1:0] b_out,
    output logic                    run_hit,
    output logic                    run_eol_bit,
    output logic [15:0]             run_cnt_out,
    output logic [4:0]              j_out
);

    rlcState_t   stateQ, stateD, stateEff;
    logic [4:0]  runIndexQ, runIndexD, runIndexEff;
    logic [15:0] runCntQ, runCntD, runCntEff;

    logic [4:0]  jVal;
    logic [15:0] cntInc;
    logic [15:0] segmentLen;
    logic [15:0] cntAfterRun;
    logic [4:0]  indexAfterRun;
    logic        segmentDone;
    logic        contextFlat;
    logic        runProc;

    logic                   outValidQ;
    logic [mode_length-1:0] modeQ, modeD;
    logic                   runHitQ, runHitD;
    logic                   runEolBitQ, runEolBitD;
    logic [15:0]            runCntOutQ, runCntOutD;
    logic [4:0]             jOutQ, jOutD;
    logic [pixel_length-1:0] xOutQ, aOutQ, bOutQ;

    // A frame_start pixel is evaluated as if the run state had just been
    // cleared, so the restart applies to that same pixel.
    always_comb begin
        stateEff    = frame_start ? ST_REGULAR : stateQ;
        runIndexEff = frame_start ? 5'd0 : runIndexQ;
        runCntEff   = frame_start ? 16'd0 : runCntQ;
    end

    run_j_table uJTable (
        .run_index_i (runIndexEff),
        .j_o         (jVal)
    );

    // Run segment arithmetic. J tops out at 15, so the count peaks at
    // 2^15 - 1 before the segment closes and the 16-bit counter never wraps.
    always_comb begin
        contextFlat   = (d == b) && (b == c) && (c == a);
        runProc       = (stateEff == ST_RUN) || contextFlat;
        cntInc        = runCntEff + 16'd1;
        segmentLen    = 16'd1 << jVal;
        segmentDone   = (cntInc == segmentLen);
        cntAfterRun   = segmentDone ? 16'd0 : cntInc;
        indexAfterRun = (segmentDone && (runIndexEff != RUN_INDEX_MAX))
                        ? runIndexEff + 5'd1 : runIndexEff;
    end

    // Next-state and next-output decision for one pixel. Without a valid
    // pixel everything holds and the flag outputs fall back to zero.
    always_comb begin
        stateD     = stateQ;
        runIndexD  = runIndexQ;
        runCntD    = runCntQ;
        modeD      = mode_length'(MODE_REGULAR);
        runHitD    = 1'b0;
        runEolBitD = 1'b0;
        runCntOutD = 16'd0;
        jOutD      = 5'd0;
        if (in_valid) begin
            stateD    = stateEff;
            runIndexD = runIndexEff;
            runCntD   = runCntEff;
            if (!runProc) begin
                stateD = ST_REGULAR;
            end else if (x == a) begin
                runHitD   = segmentDone;
                runIndexD = indexAfterRun;
                if (eol) begin
                    // End of line closes the run; a partial segment still
                    // pending is flagged with the termination bit.
                    modeD      = mode_length'(MODE_RUN_EOL);
                    runEolBitD = (cntAfterRun != 16'd0);
                    runCntD    = 16'd0;
                    stateD     = ST_REGULAR;
                end else begin
                    modeD   = mode_length'(MODE_RUN_CONTINUE);
                    runCntD = cntAfterRun;
                    stateD  = ST_RUN;
                end
            end else begin
                modeD      = mode_length'(MODE_RUN_INTERRUPT);
                runCntOutD = runCntEff;
                jOutD      = jVal;
                runIndexD  = (runIndexEff == 5'd0) ? 5'd0 : runIndexEff - 5'd1;
                runCntD    = 16'd0;
                stateD     = ST_REGULAR;
            end
        end
    end

    // State and registered outputs; reset wins over any valid pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= ST_REGULAR;
            runIndexQ  <= 5'd0;
            runCntQ    <= 16'd0;
            outValidQ  <= 1'b0;
            modeQ      <= '0;
            runHitQ    <= 1'b0;
            runEolBitQ <= 1'b0;
            runCntOutQ <= 16'd0;
            jOutQ      <= 5'd0;
            xOutQ      <= '0;
            aOutQ      <= '0;
            bOutQ      <= '0;
        end else begin
            stateQ     <= stateD;
            runIndexQ  <= runIndexD;
            runCntQ    <= runCntD;
            outValidQ  <= in_valid;
            modeQ      <= modeD;
            runHitQ    <= runHitD;
            runEolBitQ <= runEolBitD;
            runCntOutQ <= runCntOutD;
            jOutQ      <= jOutD;
            xOutQ      <= x;
            aOutQ      <= a;
            bOutQ      <= b;
        end
    end

    assign out_valid   = outValidQ;
    assign mode        = modeQ;
    assign run_hit     = runHitQ;
    assign run_eol_bit = runEolBitQ;
    assign run_cnt_out = runCntOutQ;
    assign j_out       = jOutQ;
    assign x_out       = xOutQ;
    assign a_out       = aOutQ;
    assign b_out       = bOutQ;

endmodule

// File: tb/tb_run_length_counter.sv
// ---------------------------------------------------------------------------
// tb_run_length_counter
// Directed bench for run_length_counter. Each driven pixel is run through a
// behavioural model of the run rules; the expected outputs go into a
// scoreboard queue and are popped and compared one cycle later. Directed
// spot checks against hand-derived constants back up the model.
// ---------------------------------------------------------------------------
module tb_run_length_counter;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          frame_start;
    logic          eol;
    logic [PW-1:0] x, a, b, c, d;
    logic          out_valid;
    logic [1:0]    mode;
    logic [PW-1:0] x_out, a_out, b_out;
    logic          run_hit;
    logic          run_eol_bit;
    logic [15:0]   run_cnt_out;
    logic [4:0]    j_out;

    int compared   = 0;
    int mismatched = 0;
    int hitSeen    = 0;

    typedef struct packed {
        logic          v;
        logic [1:0]    mode;
        logic [PW-1:0] x;
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic          hit;
        logic          eolBit;
        logic [15:0]   cnt;
        logic [4:0]    j;
    } expT;

    expT scoreQ[$];

    // Behavioural run state kept by the bench itself.
    bit mRun;
    int mIdx;
    int mCnt;
    int jTab [32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,
                      4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    run_length_counter dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .eol         (eol),
        .x           (x),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .out_valid   (out_valid),
        .mode        (mode),
        .x_out       (x_out),
        .a_out       (a_out),
        .b_out       (b_out),
        .run_hit     (run_hit),
        .run_eol_bit (run_eol_bit),
        .run_cnt_out (run_cnt_out),
        .j_out       (j_out)
    );

    // Single comparison point: counts it and reports on mismatch.
    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pops the oldest expectation and compares the registered outputs.
    task automatic checkOutput();
        expT ex;
        if (scoreQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard_empty observed=%0d expected=1", out_valid);
        end else begin
            ex = scoreQ.pop_front();
            checkValue("out_valid", 32'(out_valid), 32'(ex.v));
            if (ex.v) begin
                checkValue("mode",        32'(mode),        32'(ex.mode));
                checkValue("x_out",       32'(x_out),       32'(ex.x));
                checkValue("a_out",       32'(a_out),       32'(ex.a));
                checkValue("b_out",       32'(b_out),       32'(ex.b));
                checkValue("run_hit",     32'(run_hit),     32'(ex.hit));
                checkValue("run_eol_bit", 32'(run_eol_bit), 32'(ex.eolBit));
                checkValue("run_cnt_out", 32'(run_cnt_out), 32'(ex.cnt));
                checkValue("j_out",       32'(j_out),       32'(ex.j));
                if (run_hit === 1'b1) hitSeen++;
            end
        end
    endtask

    // Drives one pixel, predicts its outputs, then checks them one cycle on.
    task automatic applyStimulus(input logic v, input logic fs, input logic e,
                                 input logic [PW-1:0] px, input logic [PW-1:0] pa,
                                 input logic [PW-1:0] pb, input logic [PW-1:0] pc,
                                 input logic [PW-1:0] pd);
        expT ex;
        @(negedge clk);
        in_valid    = v;
        frame_start = fs;
        eol         = e;
        x = px; a = pa; b = pb; c = pc; d = pd;
        ex   = '0;
        ex.v = v;
        ex.x = px;
        ex.a = pa;
        ex.b = pb;
        if (v) begin
            if (fs) begin
                mRun = 1'b0;
                mIdx = 0;
                mCnt = 0;
            end
            if (!mRun && !((pd == pb) && (pb == pc) && (pc == pa))) begin
                ex.mode = 2'd0;
            end else if (px == pa) begin
                mCnt = mCnt + 1;
                if (mCnt == (1 << jTab[mIdx])) begin
                    ex.hit = 1'b1;
                    mCnt   = 0;
                    if (mIdx < 31) mIdx = mIdx + 1;
                end
                if (e) begin
                    ex.mode   = 2'd3;
                    ex.eolBit = (mCnt != 0);
                    mCnt      = 0;
                    mRun      = 1'b0;
                end else begin
                    ex.mode = 2'd1;
                    mRun    = 1'b1;
                end
            end else begin
                ex.mode = 2'd2;
                ex.cnt  = 16'(mCnt);
                ex.j    = 5'(jTab[mIdx]);
                if (mIdx > 0) mIdx = mIdx - 1;
                mCnt = 0;
                mRun = 1'b0;
            end
        end
        scoreQ.push_back(ex);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Flat neighbourhood, all samples equal to 10.
    task automatic flat(input logic fs, input logic e);
        applyStimulus(1'b1, fs, e, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10);
    endtask

    // Flat context with the current sample breaking the run.
    task automatic breakRun();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd11, 8'd10, 8'd10, 8'd10, 8'd10);
    endtask

    // Reset with a valid pixel present: every output must come back zero.
    task automatic doReset(input string tag);
        @(negedge clk);
        reset       = 1'b1;
        in_valid    = 1'b1;
        frame_start = 1'b0;
        eol         = 1'b0;
        x = 8'd10; a = 8'd10; b = 8'd10; c = 8'd10; d = 8'd10;
        @(posedge clk);
        #1;
        checkValue({tag, "_out_valid"},   32'(out_valid),   32'd0);
        checkValue({tag, "_mode"},        32'(mode),        32'd0);
        checkValue({tag, "_x_out"},       32'(x_out),       32'd0);
        checkValue({tag, "_a_out"},       32'(a_out),       32'd0);
        checkValue({tag, "_b_out"},       32'(b_out),       32'd0);
        checkValue({tag, "_run_hit"},     32'(run_hit),     32'd0);
        checkValue({tag, "_run_eol_bit"}, 32'(run_eol_bit), 32'd0);
        checkValue({tag, "_run_cnt_out"}, 32'(run_cnt_out), 32'd0);
        checkValue({tag, "_j_out"},       32'(j_out),       32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        mRun = 1'b0;
        mIdx = 0;
        mCnt = 0;
        scoreQ.delete();
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        int climbCount;
        reset = 1'b1;
        in_valid = 1'b0; frame_start = 1'b0; eol = 1'b0;
        x = '0; a = '0; b = '0; c = '0; d = '0;
        mRun = 1'b0; mIdx = 0; mCnt = 0;

        doReset("reset");

        // Flat image from reset: hits on pixels 1-4, then every second pixel.
        $display("[TB] flat run from reset");
        for (int i = 1; i <= 12; i++) begin
            flat(1'b0, 1'b0);
            checkValue($sformatf("flat_mode_%0d", i), 32'(mode), 32'd1);
            checkValue($sformatf("flat_hit_%0d", i), 32'(run_hit),
                       32'((i <= 4) || (i % 2 == 0)));
        end

        // Interruption at RUNindex 5 with one pending pixel.
        $display("[TB] run interruption");
        doReset("reset2");
        repeat (7) flat(1'b0, 1'b0);
        breakRun();
        checkValue("intr_mode", 32'(mode),        32'd2);
        checkValue("intr_cnt",  32'(run_cnt_out), 32'd1);
        checkValue("intr_j",    32'(j_out),       32'd1);
        // From index 4, seven flat pixels reach index 7 (J=1); from 5 it would be 8 (J=2).
        repeat (7) flat(1'b0, 1'b0);
        breakRun();
        checkValue("intr2_cnt", 32'(run_cnt_out), 32'd1);
        checkValue("intr2_j",   32'(j_out),       32'd1);

        // End of line: segment just closed, then a run left with residue.
        $display("[TB] end of line");
        flat(1'b1, 1'b0);
        flat(1'b0, 1'b0);
        flat(1'b0, 1'b1);
        checkValue("eol1_mode", 32'(mode),        32'd3);
        checkValue("eol1_hit",  32'(run_hit),     32'd1);
        checkValue("eol1_bit",  32'(run_eol_bit), 32'd0);
        flat(1'b0, 1'b0);
        repeat (4) flat(1'b0, 1'b0);
        flat(1'b0, 1'b1);
        checkValue("eol2_mode", 32'(mode),        32'd3);
        checkValue("eol2_hit",  32'(run_hit),     32'd0);
        checkValue("eol2_bit",  32'(run_eol_bit), 32'd1);

        // Reset mid-run with RUNcnt=3 at index 8; the run restarts from index 0.
        $display("[TB] reset mid-run");
        doReset("reset3");
        repeat (15) flat(1'b0, 1'b0);
        doReset("midrun");
        flat(1'b0, 1'b0);
        checkValue("post_reset_hit1", 32'(run_hit), 32'd1);
        flat(1'b0, 1'b0);
        checkValue("post_reset_hit2", 32'(run_hit), 32'd1);

        // Regular mode on a gradient, and a bubble in the middle of a run.
        $display("[TB] regular mode and bubbles");
        breakRun();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd10, 8'd10, 8'd10, 8'd10, 8'd12);
        checkValue("gradient_mode", 32'(mode), 32'd0);
        doReset("reset4");
        repeat (5) flat(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd99, 8'd10, 8'd10, 8'd10, 8'd10);
        checkValue("bubble_valid", 32'(out_valid), 32'd0);
        flat(1'b0, 1'b0);
        checkValue("bubble_hit", 32'(run_hit), 32'd1);

        // Climb to RUNindex 31, then one full 2^15 segment.
        $display("[TB] saturated run index");
        doReset("reset5");
        hitSeen    = 0;
        climbCount = 0;
        while (mIdx < 31 && climbCount < 40000) begin
            flat(1'b0, 1'b0);
            climbCount++;
        end
        checkValue("climb_hits", 32'(hitSeen), 32'd31);
        hitSeen = 0;
        repeat (32767) flat(1'b0, 1'b0);
        checkValue("long_hits_before", 32'(hitSeen), 32'd0);
        flat(1'b0, 1'b0);
        checkValue("long_last_hit", 32'(run_hit), 32'd1);
        checkValue("long_hits",     32'(hitSeen), 32'd1);
        breakRun();
        checkValue("sat_mode", 32'(mode),        32'd2);
        checkValue("sat_cnt",  32'(run_cnt_out), 32'd0);
        checkValue("sat_j",    32'(j_out),       32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
